// File: rtl/xv_pkg.sv
// Shared xv types and constants used by the palette (colormem) datapath.
package xv;

    typedef logic [15:0] word_t;

    localparam int COLOR_AWIDTH = 8;

endpackage

// File: rtl/colormem_writer.sv
// Write-side controller for the colormem palette: single writes and range fills.
// Optional macro COLORMEM_VBLANK_SYNC_EN holds every palette write until vblank_i is high.
module colormem_writer
    import xv::*;
#(
    parameter int AWIDTH = COLOR_AWIDTH
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_fill_i,
    input  logic              req_inc_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [AWIDTH-1:0] req_count_i,
    input  word_t             req_data_i,
    input  logic              vblank_i,
    output logic              wr_en_o,
    output logic [AWIDTH-1:0] wr_address_o,
    output word_t             wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    localparam logic [AWIDTH:0] LEFT_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [AWIDTH:0]   left;       // writes of the current fill not yet loaded
    logic [AWIDTH-1:0] nxt_addr;
    word_t             nxt_data;
    logic              fill_inc;

    logic load_ok;
    logic accept;
    logic take_fill;
    logic fill_step;

`ifdef COLORMEM_VBLANK_SYNC_EN
    assign load_ok = vblank_i;
`else
    logic unused_vblank;
    assign load_ok       = 1'b1;
    assign unused_vblank = vblank_i;
`endif

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE) | wr_en_o;
    assign accept      = req_valid_i & req_ready_o;
    assign take_fill   = accept & req_fill_i;
    assign fill_step   = (state == FILL) && (left != '0) && load_ok;

    function automatic word_t data_step(input word_t d, input logic inc);
        return d + {15'd0, inc};
    endfunction

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            left         <= '0;
            wr_en_o      <= 1'b0;
            wr_address_o <= '0;
            wr_data_o    <= '0;
            done_o       <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_fill) begin
                        state <= FILL;
                        if (load_ok) begin
                            wr_en_o      <= 1'b1;
                            wr_address_o <= req_addr_i;
                            wr_data_o    <= req_data_i;
                            done_o       <= (req_count_i == '0);
                            left         <= {1'b0, req_count_i};
                        end else begin
                            left <= {1'b0, req_count_i} + LEFT_ONE;
                        end
                    end else if (accept) begin
`ifdef COLORMEM_VBLANK_SYNC_EN
                        state <= PEND;
`else
                        wr_en_o      <= 1'b1;
                        wr_address_o <= req_addr_i;
                        wr_data_o    <= req_data_i;
`endif
                    end
                end
`ifdef COLORMEM_VBLANK_SYNC_EN
                PEND: begin
                    if (load_ok) begin
                        wr_en_o      <= 1'b1;
                        wr_address_o <= nxt_addr;
                        wr_data_o    <= nxt_data;
                        state        <= IDLE;
                    end
                end
`endif
                FILL: begin
                    // Leaving on the edge after the last write keeps ready low through it
                    if (left == '0) begin
                        state <= IDLE;
                    end else if (load_ok) begin
                        wr_en_o      <= 1'b1;
                        wr_address_o <= nxt_addr;
                        wr_data_o    <= nxt_data;
                        done_o       <= (left == LEFT_ONE);
                        left         <= left - LEFT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data counters (no reset: always loaded before use)
    always_ff @(posedge clk) begin
        if (take_fill) begin
            fill_inc <= req_inc_i;
            if (load_ok) begin
                nxt_addr <= req_addr_i + 1'b1;
                nxt_data <= data_step(req_data_i, req_inc_i);
            end else begin
                nxt_addr <= req_addr_i;
                nxt_data <= req_data_i;
            end
        end else if (accept) begin
            nxt_addr <= req_addr_i;
            nxt_data <= req_data_i;
        end else if (fill_step) begin
            nxt_addr <= nxt_addr + 1'b1;
            nxt_data <= data_step(nxt_data, fill_inc);
        end
    end

endmodule

// File: tb/tb_colormem_writer.sv
// Directed bench for colormem_writer with a queue-based write model.
module tb_colormem_writer;
    import xv::*;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_fill_i = 1'b0;
    logic       req_inc_i = 1'b0;
    logic [7:0] req_addr_i = '0;
    logic [7:0] req_count_i = '0;
    word_t      req_data_i = '0;
    logic       vblank_i = 1'b0;
    logic       wr_en_o;
    logic [7:0] wr_address_o;
    word_t      wr_data_o;
    logic       busy_o;
    logic       done_o;

    colormem_writer #(.AWIDTH(8)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_fill_i   (req_fill_i),
        .req_inc_i    (req_inc_i),
        .req_addr_i   (req_addr_i),
        .req_count_i  (req_count_i),
        .req_data_i   (req_data_i),
        .vblank_i     (vblank_i),
        .wr_en_o      (wr_en_o),
        .wr_address_o (wr_address_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        word_t      data;
        logic       done;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic vb_edge = 1'b0;
    logic [7:0] last_a = '0;
    word_t last_d = '0;
    wr_t cur_e;
    wr_t cur_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic wr_t getlog(input int i);
        wr_t z;
        z = '{0, 8'h00, 16'h0000, 1'b0};
        if (i >= 0 && i < log_q.size()) z = log_q[i];
        return z;
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        vb_edge <= vblank_i;
    end

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!reset_n_i) begin
            last_a <= '0;
            last_d <= '0;
        end else begin
            chk("busy_rule", {31'd0, busy_o}, {31'd0, (!req_ready_o) | wr_en_o});
            if (wr_en_o) begin
                cur_w = '{cyc, wr_address_o, wr_data_o, done_o};
                log_q.push_back(cur_w);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                             wr_address_o, wr_data_o);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, wr_address_o}, {24'd0, cur_e.addr});
                    chk("wr_data", {16'd0, wr_data_o}, {16'd0, cur_e.data});
                    chk("wr_done", {31'd0, done_o}, {31'd0, cur_e.done});
                end
`ifdef COLORMEM_VBLANK_SYNC_EN
                chk("vblank_gate", {31'd0, vb_edge}, 32'd1);
`endif
                last_a <= wr_address_o;
                last_d <= wr_data_o;
            end else begin
                chk("hold_addr", {24'd0, wr_address_o}, {24'd0, last_a});
                chk("hold_data", {16'd0, wr_data_o}, {16'd0, last_d});
                chk("done_without_write", {31'd0, done_o}, 32'd0);
            end
        end
    end

    // Handshake one request and push the writes it must produce into the model.
    task automatic send(input logic fill, input logic inc, input logic [7:0] addr,
                        input logic [7:0] cnt, input word_t data, output int waited);
        logic [7:0] a;
        word_t d;
        wr_t e;
        waited = 0;
        while (!req_ready_o && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_o) begin
            $display("FAIL handshake_timeout: got ready 0, required 1");
            $fatal(1, "ready never returned");
        end
        req_valid_i = 1'b1;
        req_fill_i  = fill;
        req_inc_i   = inc;
        req_addr_i  = addr;
        req_count_i = cnt;
        req_data_i  = data;
        @(posedge clk);
        #1;
        if (!fill) begin
            e = '{0, addr, data, 1'b0};
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k <= int'(cnt); k++) begin
                a = addr + 8'(k);
                d = data + (inc ? 16'(k) : 16'd0);
                e = '{0, a, d, (k == int'(cnt))};
                exp_q.push_back(e);
            end
        end
    endtask

    // After a fill is accepted: n gap-free write cycles, then ready back the next cycle.
    task automatic fill_run(input int n, input logic hold_valid);
        int bad;
        bad = 0;
        if (hold_valid) begin
            req_fill_i = 1'b0;
            req_addr_i = 8'hAA;
            req_data_i = 16'hDEAD;
        end else begin
            req_valid_i = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!wr_en_o || req_ready_o || !busy_o) bad++;
            if (k == n - 1) req_valid_i = 1'b0;
        end
        @(negedge clk);
        chk("fill_gap_cycles", bad, 0);
        chk("ready_after_fill", {31'd0, req_ready_o}, 32'd1);
        chk("idle_after_fill", {31'd0, wr_en_o | busy_o}, 32'd0);
    endtask

    initial begin
        int w0, w1, w2, b, wcount;
        bit fin;
        wr_t l0, l1, l2;
`ifdef COLORMEM_VBLANK_SYNC_EN
        vblank_i = 1'b1;
`endif
        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_outs", {15'd0, wr_en_o, busy_o, done_o, wr_address_o, 6'd0}, 32'd0);
        chk("rst_data", {16'd0, wr_data_o}, 32'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("post_rst_idle", {29'd0, wr_en_o, busy_o, done_o}, 32'd0);

        // Back-to-back single writes
        b = log_q.size();
        send(1'b0, 1'b0, 8'h10, 8'h00, 16'h0F00, w0);
        send(1'b0, 1'b0, 8'h11, 8'h00, 16'h00F0, w1);
        send(1'b0, 1'b0, 8'h12, 8'h00, 16'h000F, w2);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_count", log_q.size() - b, 3);
        l0 = getlog(b);
        l2 = getlog(b + 2);
        chk("b2b_first", {8'd0, l0.addr, l0.data}, 32'h00100F00);
        chk("b2b_last", {8'd0, l2.addr, l2.data}, 32'h0012000F);
`ifndef COLORMEM_VBLANK_SYNC_EN
        chk("b2b_ready_waits", w0 + w1 + w2, 0);
        chk("b2b_consecutive", l2.cyc - l0.cyc, 2);
`endif

        // Fill wrapping past the top entry
        b = log_q.size();
        send(1'b1, 1'b1, 8'hFE, 8'd3, 16'h1234, w0);
        fill_run(4, 1'b0);
        l0 = getlog(b);
        l1 = getlog(b + 2);
        l2 = getlog(b + 3);
        chk("wrap_w0", {7'd0, l0.done, l0.addr, l0.data}, 32'h00FE1234);
        chk("wrap_w2", {7'd0, l1.done, l1.addr, l1.data}, 32'h00001236);
        chk("wrap_w3_done", {7'd0, l2.done, l2.addr, l2.data}, 32'h01011237);

        // Full-range constant fill with valid held high throughout
        b = log_q.size();
        send(1'b1, 1'b0, 8'h00, 8'hFF, 16'h0000, w0);
        fill_run(256, 1'b1);
        chk("full_count", log_q.size() - b, 256);
        l2 = getlog(b + 255);
        chk("full_last", {7'd0, l2.done, l2.addr, l2.data}, 32'h01FF0000);

        // Single-entry fill
        send(1'b1, 1'b1, 8'h80, 8'd0, 16'hFFFF, w0);
        fill_run(1, 1'b0);

`ifdef COLORMEM_VBLANK_SYNC_EN
        // Vblank-gated fill
        vblank_i = 1'b0;
        b = log_q.size();
        send(1'b1, 1'b1, 8'h30, 8'd9, 16'h0700, w0);
        req_valid_i = 1'b0;
        wcount = 0;
        fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge clk);
            if (wr_en_o) wcount++;
            if (done_o) fin = 1'b1;
            vblank_i = ((i / 4) % 2) == 0;
        end
        chk("vb_finished", {31'd0, fin}, 32'd1);
        chk("vb_count", wcount, 10);
        @(negedge clk);
        chk("vb_ready_after", {31'd0, req_ready_o}, 32'd1);
        vblank_i = 1'b1;
`endif

        // Reset in the middle of a fill
        b = log_q.size();
        send(1'b1, 1'b1, 8'h40, 8'd7, 16'h0100, w0);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("midrst_done_busy", {30'd0, done_o, busy_o}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("midrst_writes", log_q.size() - b, 3);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);
        b = log_q.size();
        send(1'b0, 1'b0, 8'h05, 8'h00, 16'h0ABC, w0);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        l0 = getlog(b);
        chk("post_rst_write", {7'd0, l0.done, l0.addr, l0.data}, 32'h00050ABC);
        chk("post_rst_count", log_q.size() - b, 1);

        chk("model_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule
